// File: rtl/uart_baud_lock_ctrl.sv
// Autobaud lock sequencer: measures two 0x55 sync frames on the raw RX line and publishes a locked bit-period divisor.
// Latency: 2-FF synchronizer plus one edge-detect stage; lock asserts one candidate period after the sync stop-bit edge.
module uart_baud_lock_ctrl #(
  parameter int DIV_W     = 16,
  parameter int MIN_DIV   = 16,
  parameter int MAX_DIV   = 20833,
  parameter int TOL_SHIFT = 4,
  parameter int ERR_LIMIT = 4,
  parameter int GAP_BITS  = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_uart_rx,
  input  logic             i_rx_vld,
  input  logic             i_frame_err,
  input  logic             i_relock_req,
  output logic [DIV_W-1:0] o_baud_div,
  output logic             o_locked,
  output logic             o_relock,
  output logic [2:0]       o_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MEAS1  = 3'd1,
    S_GAP    = 3'd2,
    S_VERIFY = 3'd3,
    S_STOP   = 3'd4,
    S_LOCKED = 3'd5
  } state_t;

  localparam int ACC_W  = DIV_W + 3;
  localparam int IDLE_W = DIV_W + $clog2(GAP_BITS) + 1;
  localparam int ERR_W  = $clog2(ERR_LIMIT + 1);
  localparam logic [DIV_W-1:0] SEG_SAT = DIV_W'(MAX_DIV + 1);

  state_t             r_state;
  logic               r_rx_s1, r_rx_s2, r_rx_d;
  logic [DIV_W-1:0]   r_seg;
  logic [DIV_W-1:0]   r_cand;
  logic [ACC_W-1:0]   r_acc;
  logic [2:0]         r_edges;
  logic               r_hi;
  logic [IDLE_W-1:0]  r_idle;
  logic [ERR_W-1:0]   r_err;

  logic               w_fall, w_rise, w_edge;
  logic               w_seg_short, w_seg_long;
  logic [ACC_W-1:0]   w_acc_nxt, w_round;
  logic [DIV_W-1:0]   w_meas, w_diff, w_tol;
  logic [IDLE_W-1:0]  w_cand_ext, w_gap_lim;
  logic [ERR_W-1:0]   w_err_nxt;

  assign w_fall      = r_rx_d & ~r_rx_s2;
  assign w_rise      = ~r_rx_d & r_rx_s2;
  assign w_edge      = w_fall | w_rise;
  assign w_seg_short = r_seg < DIV_W'(MIN_DIV);
  assign w_seg_long  = r_seg > DIV_W'(MAX_DIV);
  assign w_acc_nxt   = r_acc + ACC_W'(r_seg);
  assign w_round     = w_acc_nxt + ACC_W'(4);
  assign w_meas      = DIV_W'(w_round >> 3);
  assign w_diff      = (w_meas > r_cand) ? (w_meas - r_cand) : (r_cand - w_meas);
  assign w_tol       = r_cand >> TOL_SHIFT;
  assign w_cand_ext  = IDLE_W'(r_cand);
  assign w_gap_lim   = IDLE_W'(GAP_BITS) * w_cand_ext;
  assign w_err_nxt   = r_err + ERR_W'(1);
  assign o_state     = r_state;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_d     <= 1'b1;
      r_seg      <= '0;
      r_cand     <= '0;
      r_acc      <= '0;
      r_edges    <= '0;
      r_hi       <= 1'b0;
      r_idle     <= '0;
      r_err      <= '0;
      o_baud_div <= '0;
      o_locked   <= 1'b0;
      o_relock   <= 1'b0;
    end else begin
      r_rx_s1  <= i_uart_rx;
      r_rx_s2  <= r_rx_s1;
      r_rx_d   <= r_rx_s2;
      o_relock <= 1'b0;
      // Segment counter restarts on every edge and saturates just past the legal range.
      if (w_edge)                r_seg <= DIV_W'(1);
      else if (r_seg != SEG_SAT) r_seg <= r_seg + DIV_W'(1);

      if (i_relock_req && r_state != S_LOCKED) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_fall) begin
              r_state <= S_MEAS1;
              r_acc   <= '0;
              r_edges <= '0;
            end
          end
          S_MEAS1, S_VERIFY: begin
            if (w_seg_long || (w_edge && w_seg_short)) begin
              r_state <= S_IDLE;
            end else if (w_edge) begin
              r_acc   <= w_acc_nxt;
              r_edges <= r_edges + 3'd1;
              if (r_edges == 3'd7) begin
                r_hi   <= 1'b0;
                r_idle <= '0;
                if (r_state == S_VERIFY && w_diff <= w_tol) begin
                  r_state <= S_STOP;
                end else begin
                  r_cand  <= w_meas;
                  r_state <= S_GAP;
                end
              end
            end
          end
          S_GAP: begin
            if (!r_hi) begin
              if (w_seg_long) r_state <= S_IDLE;
              else if (w_rise) begin
                r_hi   <= 1'b1;
                r_idle <= IDLE_W'(1);
              end
            end else if (w_fall) begin
              r_state <= S_VERIFY;
              r_acc   <= '0;
              r_edges <= '0;
            end else if (r_idle > w_gap_lim) begin
              r_state <= S_IDLE;
            end else begin
              r_idle <= r_idle + IDLE_W'(1);
            end
          end
          S_STOP: begin
            if (!r_hi) begin
              if (w_seg_long) r_state <= S_IDLE;
              else if (w_rise) begin
                r_hi   <= 1'b1;
                r_idle <= IDLE_W'(1);
              end
            end else if (w_fall) begin
              r_state <= S_IDLE;
            end else if (r_idle >= w_cand_ext) begin
              o_baud_div <= r_cand;
              o_locked   <= 1'b1;
              r_err      <= '0;
              r_state    <= S_LOCKED;
            end else begin
              r_idle <= r_idle + IDLE_W'(1);
            end
          end
          S_LOCKED: begin
            // A framing error in the same cycle as a good byte still counts.
            if (i_relock_req || (i_frame_err && w_err_nxt >= ERR_W'(ERR_LIMIT))) begin
              o_locked <= 1'b0;
              o_relock <= 1'b1;
              r_err    <= '0;
              r_state  <= S_IDLE;
            end else if (i_frame_err) begin
              r_err <= w_err_nxt;
            end else if (i_rx_vld) begin
              r_err <= '0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_baud_lock_ctrl.sv
// Bench for uart_baud_lock_ctrl: drives 0x55 sync frames, scoreboards expected lock divisors against lock events.
module tb_uart_baud_lock_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_uart_rx;
  logic        i_rx_vld;
  logic        i_frame_err;
  logic        i_relock_req;
  logic [15:0] o_baud_div;
  logic        o_locked;
  logic        o_relock;
  logic [2:0]  o_state;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_div_q[$];
  logic prev_locked = 1'b0;

  uart_baud_lock_ctrl dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_uart_rx    (i_uart_rx),
    .i_rx_vld     (i_rx_vld),
    .i_frame_err  (i_frame_err),
    .i_relock_req (i_relock_req),
    .o_baud_div   (o_baud_div),
    .o_locked     (o_locked),
    .o_relock     (o_relock),
    .o_state      (o_state)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard: every rising o_locked consumes one expected divisor.
  always @(negedge i_clk) begin
    if (o_locked && !prev_locked) begin
      if (exp_div_q.size() == 0) chk("unexpected_lock", 32'(o_baud_div), 32'd0);
      else chk("lock_div", 32'(o_baud_div), 32'(exp_div_q.pop_front()));
    end
    prev_locked = o_locked;
  end

  task automatic line(input logic v, input int cyc);
    i_uart_rx = v;
    repeat (cyc) @(negedge i_clk);
  endtask

  // Start bit plus 8 data bits of 0x55; leaves the line high (stop bit begins).
  task automatic send_frame(input int n);
    logic [7:0] byt;
    byt = 8'h55;
    line(1'b0, n);
    for (int b = 0; b < 8; b++) line(byt[b], n);
    i_uart_rx = 1'b1;
  endtask

  task automatic pulse_err();
    i_frame_err = 1'b1; @(negedge i_clk); i_frame_err = 1'b0;
  endtask

  task automatic pulse_vld();
    i_rx_vld = 1'b1; @(negedge i_clk); i_rx_vld = 1'b0;
  endtask

  task automatic pulse_relock();
    i_relock_req = 1'b1; @(negedge i_clk); i_relock_req = 1'b0;
  endtask

  // Called right after the stop bit goes high; checks lock arrives about n clocks later.
  task automatic wait_lock(input string tag, input int n);
    int k;
    k = 0;
    while (!o_locked && k < n + 50) begin
      @(negedge i_clk);
      k++;
    end
    chk({tag, "_lat"}, 32'((k >= n - 3) && (k <= n + 3)), 32'd1);
    chk({tag, "_state"}, 32'(o_state), 32'd5);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1; i_uart_rx = 1'b1; i_rx_vld = 1'b0; i_frame_err = 1'b0; i_relock_req = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("rst_div", 32'(o_baud_div), 32'd0);
    chk("rst_locked", 32'(o_locked), 32'd0);
    chk("rst_relock", 32'(o_relock), 32'd0);
    chk("rst_state", 32'(o_state), 32'd0);
    i_rst = 1'b0;
    repeat (5) @(negedge i_clk);

    // Two frames at 115200
    exp_div_q.push_back(434);
    send_frame(434);
    line(1'b1, 868);
    send_frame(434);
    wait_lock("lock434", 434);

    // Error counter: err, good, err, err, err keeps lock
    pulse_err(); pulse_vld(); pulse_err(); pulse_err(); pulse_err();
    chk("err3_locked", 32'(o_locked), 32'd1);
    pulse_vld();
    pulse_err(); pulse_err(); pulse_err();
    chk("err3b_relock", 32'(o_relock), 32'd0);
    pulse_err();
    chk("err4_relock", 32'(o_relock), 32'd1);
    chk("err4_locked", 32'(o_locked), 32'd0);
    chk("err4_state", 32'(o_state), 32'd0);
    chk("err4_div_held", 32'(o_baud_div), 32'd434);
    @(negedge i_clk);
    chk("relock_one_cycle", 32'(o_relock), 32'd0);

    // Glitch and stuck-low aborts
    line(1'b0, 5);
    line(1'b1, 50);
    chk("glitch_state", 32'(o_state), 32'd0);
    line(1'b0, 100);
    chk("meas_state", 32'(o_state), 32'd1);
    line(1'b0, 20900);
    chk("stuck_low_state", 32'(o_state), 32'd0);
    line(1'b1, 50);
    chk("stuck_low_locked", 32'(o_locked), 32'd0);
    line(1'b0, 100);
    pulse_relock();
    chk("req_unlocked_relock", 32'(o_relock), 32'd0);
    chk("req_unlocked_state", 32'(o_state), 32'd0);
    line(1'b1, 50);

    // 115200 then 57600 twice: candidate replaced, lock at 868
    exp_div_q.push_back(868);
    send_frame(434);
    line(1'b1, 868);
    send_frame(868);
    line(1'b1, 1736);
    chk("mismatch_state", 32'(o_state), 32'd2);
    chk("mismatch_locked", 32'(o_locked), 32'd0);
    send_frame(868);
    wait_lock("lock868", 868);

    // Software relock, then 230400
    pulse_relock();
    chk("sw_relock", 32'(o_relock), 32'd1);
    chk("sw_locked", 32'(o_locked), 32'd0);
    chk("sw_state", 32'(o_state), 32'd0);
    chk("sw_div_held", 32'(o_baud_div), 32'd868);
    line(1'b1, 50);
    exp_div_q.push_back(217);
    send_frame(217);
    line(1'b1, 434);
    send_frame(217);
    wait_lock("lock217", 217);

    // Reset in the middle of the verify frame
    pulse_relock();
    line(1'b1, 50);
    send_frame(217);
    line(1'b1, 434);
    line(1'b0, 217);
    line(1'b1, 217);
    line(1'b0, 217);
    line(1'b1, 100);
    chk("verify_state", 32'(o_state), 32'd3);
    i_rst = 1'b1;
    #1;
    chk("midrst_div", 32'(o_baud_div), 32'd0);
    chk("midrst_locked", 32'(o_locked), 32'd0);
    chk("midrst_state", 32'(o_state), 32'd0);
    @(negedge i_clk);
    line(1'b1, 117);
    line(1'b0, 217);
    line(1'b1, 217);
    line(1'b0, 217);
    line(1'b1, 500);
    i_rst = 1'b0;
    line(1'b1, 50);
    exp_div_q.push_back(217);
    send_frame(217);
    line(1'b1, 434);
    send_frame(217);
    wait_lock("relock217", 217);

    repeat (10) @(negedge i_clk);
    chk("sb_empty", 32'(exp_div_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
